// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed Booth multiply / restoring divide with HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to let a multiply with a zero operand skip straight to FINISH.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             MultStop,
  output logic             DivStop,
  output logic             DivZero,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FINISH, DZERO} state_t;
  state_t state, next;
  logic [5:0] cnt;
  logic [2*WIDTH+1:0] acc, acc_next;
  logic [WIDTH:0] m, hi_in, op, sum;
  logic [WIDTH-1:0] abs_a, abs_b, q, r;
  logic is_mul, neg_q, neg_r, early;
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;
`ifdef MULDIV_EARLY_OUT_EN
  assign early = (A == '0) || (B == '0);
`else
  assign early = 1'b0;
`endif
  assign busy = state != IDLE;
  assign q = acc[WIDTH:1];
  assign r = acc[2*WIDTH:WIDTH+1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:             next = MultCtrl ? (early ? FINISH : MUL_RUN) : DivCtrl ? (B == '0 ? DZERO : DIV_RUN) : IDLE;
      MUL_RUN, DIV_RUN: next = cnt == 6'd1 ? FINISH : state;
      default:          next = IDLE;
    endcase
  end
  // Multiply: acc = {P_hi(W+1), P_lo(W), q-1}; divide: acc = {R(W+1), Q(W), 0}.
  always_comb begin
    hi_in    = is_mul ? acc[2*WIDTH+1:WIDTH+1] : {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
    op       = (!is_mul || acc[1:0] == 2'b10) ? -m : acc[1:0] == 2'b01 ? m : '0;
    sum      = hi_in + op;
    acc_next = is_mul ? {sum[WIDTH], sum, acc[WIDTH:1]}
                      : {sum[WIDTH] ? hi_in : sum, acc[WIDTH-1:1], ~sum[WIDTH], 1'b0};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      is_mul   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      MultStop <= 1'b0;
      DivStop  <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      MultStop <= state == FINISH && is_mul;
      DivStop  <= state == FINISH && !is_mul;
      DivZero  <= state == DZERO;
      if (state == IDLE) begin
        cnt    <= 6'(WIDTH);
        is_mul <= MultCtrl;
        neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_r  <= A[WIDTH-1];
        m      <= MultCtrl ? {A[WIDTH-1], A} : {1'b0, abs_b};
        acc    <= MultCtrl ? (early ? '0 : {{(WIDTH+1){1'b0}}, B, 1'b0})
                           : {{(WIDTH+1){1'b0}}, abs_a, 1'b0};
      end else if (state == MUL_RUN || state == DIV_RUN) begin
        cnt <= cnt - 6'd1;
        acc <= acc_next;
      end
      if (state == FINISH) begin
        HI <= (!is_mul && neg_r) ? -r : r;
        LO <= (!is_mul && neg_q) ? -q : q;
      end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
  logic clk = 1'b0, reset = 1'b0, MultCtrl = 1'b0, DivCtrl = 1'b0;
  logic [31:0] A = '0, B = '0, HI, LO;
  logic MultStop, DivStop, DivZero, busy;
  int n_chk = 0, n_pass = 0, lat, cnt;
  logic [2:0] st;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl), .A(A), .B(B),
    .HI(HI), .LO(LO), .MultStop(MultStop), .DivStop(DivStop), .DivZero(DivZero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Starts an op, optionally pulses DivCtrl mid-run, returns latency and {MultStop,DivStop,DivZero}.
  task automatic run(input logic mc, input logic dc, input logic [31:0] a, input logic [31:0] b,
                     input int mid, output int l, output logic [2:0] s);
    @(negedge clk);
    MultCtrl = mc; DivCtrl = dc; A = a; B = b;
    @(posedge clk); #1;
    MultCtrl = 1'b0; DivCtrl = 1'b0;
    check("busy_at_start", busy, 1);
    l = -1; s = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      DivCtrl = (i == mid);
      if (MultStop | DivStop | DivZero) begin
        l = i; s = {MultStop, DivStop, DivZero};
        break;
      end
    end
    DivCtrl = 1'b0;
    check("busy_at_stop", busy, 0);
    @(posedge clk); #1;
    check("pulse_one_cycle", {MultStop, DivStop, DivZero}, 0);
  endtask

  initial begin
    #12;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_flags", {MultStop, DivStop, DivZero, busy}, 0);
    @(negedge clk); reset = 1'b1;

    run(1, 0, 32'hFFFF_FFFD, 32'd7, 0, lat, st);
    check("mul_neg_lat", lat, 33);
    check("mul_neg_kind", st, 3'b100);
    check("mul_neg_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

    run(1, 0, 32'h8000_0000, 32'h8000_0000, 0, lat, st);
    check("mul_min_hilo", {HI, LO}, 64'h4000_0000_0000_0000);

    run(0, 1, 32'hFFFF_FFF9, 32'd2, 0, lat, st);
    check("div_neg_lat", lat, 33);
    check("div_neg_kind", st, 3'b010);
    check("div_neg_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    run(0, 1, 32'd5, 32'd0, 0, lat, st);
    check("dz_lat", lat, 1);
    check("dz_kind", st, 3'b001);
    check("dz_hilo_hold", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (DivStop || DivZero) cnt++;
    end
    check("dz_no_more_pulses", cnt, 0);

    run(1, 1, 32'd6, 32'd4, 10, lat, st);
    check("both_lat", lat, 33);
    check("both_kind", st, 3'b100);
    check("both_hilo", {HI, LO}, 64'd24);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || DivStop) cnt++;
    end
    check("mid_div_ignored", cnt, 0);

    run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, st);
    check("div_wrap_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

    run(0, 1, 32'd7, 32'hFFFF_FFFE, 0, lat, st);
    check("div_pos_neg_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFD);

    @(negedge clk);
    MultCtrl = 1'b1; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    MultCtrl = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("abort_hilo", {HI, LO}, 0);
    check("abort_flags", {MultStop, DivStop, DivZero, busy}, 0);
    @(negedge clk); reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (MultStop || busy) cnt++;
    end
    check("abort_no_stop", cnt, 0);

    run(1, 0, 32'h1234, 32'd0, 0, lat, st);
`ifdef MULDIV_EARLY_OUT_EN
    check("mul_zero_lat", lat, 1);
`else
    check("mul_zero_lat", lat, 33);
`endif
    check("mul_zero_kind", st, 3'b100);
    check("mul_zero_hilo", {HI, LO}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative signed multiply/divide unit, including its own sequencing FSM, for the multicycle CPU. The control unit starts an operation with `MultCtrl` or `DivCtrl`, then waits in a wait state until `MultStop`, `DivStop` or `DivZero` is asserted. The block owns the HI/LO result registers read by MFHI/MFLO. One operation runs at a time: a single shift/add datapath is shared between MULT and DIV.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `MultCtrl`  in  1: start signed multiply. Sampled in IDLE only.
- `DivCtrl`  in  1: start signed divide. Sampled in IDLE only.
- `A`  in  WIDTH: rs operand (multiplicand / dividend). Latched on the start edge.
- `B`  in  WIDTH: rt operand (multiplier / divisor). Latched on the start edge.
- `HI`  out  WIDTH: product upper half / remainder.
- `LO`  out  WIDTH: product lower half / quotient.
- `MultStop`  out  1: one-cycle pulse; multiply result valid on HI/LO.
- `DivStop`  out  1: one-cycle pulse; divide result valid on HI/LO.
- `DivZero`  out  1: one-cycle pulse; divide by zero detected, no result written.
- `busy`  out  1: high from the start edge until the stop or zero pulse is raised.

## Operation
- Reset value of all outputs and registers: 0. State goes to IDLE.
- Reset asserted mid-operation aborts the operation. HI/LO are cleared, and no stop pulse is generated.
- States:
  - IDLE
    - `MultCtrl`=1 → MUL_RUN.
    - Otherwise `DivCtrl`=1 and B≠0 → DIV_RUN.
    - `DivCtrl`=1 and B=0 → DZERO.
  - MUL_RUN: 32 iterations → FINISH.
  - DIV_RUN: 32 iterations → FINISH.
  - FINISH: writes HI/LO and pulses MultStop or DivStop → IDLE.
  - DZERO: pulses DivZero; HI/LO unchanged → IDLE.
- `MultCtrl` and `DivCtrl` high together: multiply wins, and the divide is dropped.
- Start requests while busy are ignored; they are not queued.
- Iteration counter: 6 bits, loaded with `WIDTH`, decremented each RUN cycle. RUN exits when the counter decrements to 0.
- Multiply: radix-2 Booth on a 2·WIDTH+1-bit product register {P_hi, P_lo, q₋₁}.
  - Each cycle, from {q₀, q₋₁}:
    - 01: add A to P_hi.
    - 10: subtract A from P_hi.
    - 00/11: no add.
  - Then arithmetic-shift the whole register right 1.
  - Result is {HI, LO} = full signed 64-bit product.
  - Special case: A = −2^31 is handled by a WIDTH+1-bit adder.
- Divide: restoring division on magnitudes |A|, |B|.
  - Each cycle: shift {R, Q} left 1, trial-subtract |B| from R, restore if the result is negative, and set Q₀.
  - In FINISH:
    - LO = Q, negated if sign(A)≠sign(B).
    - HI = R, negated if A<0.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - −2^31 / −1: LO = 0x80000000, HI = 0 (wraps; no exception).
- HI/LO change only in FINISH, or on reset. They hold their value between operations.

## Timing
- Start sampled at edge N; busy=1 from edge N.
- Edges N+1 … N+32: iterations (MUL_RUN / DIV_RUN).
- Edge N+33: HI/LO loaded, and MultStop/DivStop registered high. busy falls at the same edge.
- Stop pulse is high for exactly one cycle (edge N+33 to N+34). A new start is accepted at edge N+34.
- Divide by zero: DivZero high for one cycle from edge N+1. busy is high only from edge N to N+1.
- Back-to-back: a start held continuously high re-triggers at edge N+34.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: a multiply with A=0 or B=0 at start skips MUL_RUN and goes straight to FINISH. HI=LO=0, and MultStop rises at edge N+1.
  - Undefined: every multiply takes the full 33-cycle latency. Divide timing is unaffected either way.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=7 → MultStop at edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT A=0x80000000, B=0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV A=−7, B=2 → DivStop at N+33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 → DivZero pulses at N+1 only; HI/LO keep their previous values; DivStop never rises.
- MultCtrl and DivCtrl together with A=6, B=4 → multiply runs: HI=0, LO=24. A DivCtrl pulse mid-run is ignored.
- Reset low at edge N+10 of a multiply → all outputs 0 immediately; no MultStop. With `MULDIV_EARLY_OUT_EN`, MULT B=0 → MultStop at N+1 with HI=LO=0.
